// File: rtl/armleocpu_ptw_sv32.sv
// Sv32 page-table walker: resolves a VPN through up to two PTE reads and
// returns the leaf PPN and access bits, or a page/access fault.
module armleocpu_ptw_sv32 #(
  parameter bit ENABLE_SUPERPAGE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [21:0] satp_ppn,
  input  logic        resolve_request,
  input  logic [19:0] resolve_virtual_address,
  output logic        resolve_busy,
  output logic        resolve_done,
  output logic        resolve_pagefault,
  output logic        resolve_accessfault,
  output logic [21:0] resolve_physical_address,
  output logic [7:0]  resolve_access_bits,
  output logic        mem_read,
  output logic [33:0] mem_address,
  input  logic        mem_done,
  input  logic        mem_error,
  input  logic [31:0] mem_readdata,
  output logic        tlb_write,
  output logic [19:0] tlb_virtual_address_w,
  output logic [7:0]  tlb_accesstag_w,
  output logic [21:0] tlb_phys_w
);

  localparam int unsigned PPN_W  = 22;
  localparam int unsigned VPN_W  = 20;
  localparam int unsigned ADDR_W = 34;
  localparam int unsigned BITS_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_L1   = 2'd1,
    S_L0   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [VPN_W-1:0]    vaddr_q, vaddr_d;
  logic                mem_read_q, mem_read_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pf_q, pf_d;
  logic                af_q, af_d;
  logic [PPN_W-1:0]    ppn_q, ppn_d;
  logic [BITS_W-1:0]   bits_q, bits_d;
  logic [VPN_W-1:0]    tlb_va_q, tlb_va_d;
  logic                tlbw_q, tlbw_d;

  logic                leaf_ok;
  logic [PPN_W-1:0]    leaf_ppn;

  logic pte_v, pte_r, pte_w, pte_x, pte_leaf;
  assign pte_v    = mem_readdata[0];
  assign pte_r    = mem_readdata[1];
  assign pte_w    = mem_readdata[2];
  assign pte_x    = mem_readdata[3];
  assign pte_leaf = pte_r | pte_x;

  // RSW bits are neither checked nor forwarded
  logic unused_pte_rsw;
  assign unused_pte_rsw = ^mem_readdata[9:8];

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    vaddr_d    = vaddr_q;
    mem_read_d = mem_read_q;
    mem_addr_d = mem_addr_q;
    done_d     = 1'b0;
    pf_d       = 1'b0;
    af_d       = 1'b0;
    ppn_d      = ppn_q;
    bits_d     = bits_q;
    tlb_va_d   = tlb_va_q;
    tlbw_d     = 1'b0;
    leaf_ok    = 1'b0;
    leaf_ppn   = '0;

    case (state_q)
      S_IDLE: begin
        if (resolve_request) begin
          vaddr_d    = resolve_virtual_address;
          mem_addr_d = {satp_ppn, resolve_virtual_address[19:10], 2'b00};
          mem_read_d = 1'b1;
          state_d    = S_L1;
        end
      end
      S_L1, S_L0: begin
        if (mem_read_q && mem_done) begin
          mem_read_d = 1'b0;
          state_d    = S_DONE;
          if (mem_error) begin
            af_d = 1'b1;
          end else if (!pte_v || (pte_w && !pte_r)) begin
            pf_d = 1'b1;
          end else if (pte_leaf) begin
            if (state_q == S_L0) begin
              leaf_ok  = 1'b1;
              leaf_ppn = mem_readdata[31:10];
            end else if (ENABLE_SUPERPAGE && (mem_readdata[19:10] == 10'd0)) begin
              leaf_ok  = 1'b1;
              leaf_ppn = {mem_readdata[31:20], vaddr_q[9:0]};
            end else begin
              pf_d = 1'b1;
            end
          end else if (state_q == S_L1) begin
            // Pointer PTE: address for the L0 read is parked while mem_read is low
            state_d    = S_L0;
            mem_addr_d = {mem_readdata[31:10], vaddr_q[9:0], 2'b00};
          end else begin
            pf_d = 1'b1;
          end
        end else if ((state_q == S_L0) && !mem_read_q) begin
          mem_read_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    done_d = (state_d == S_DONE);
    if (leaf_ok) begin
      ppn_d    = leaf_ppn;
      bits_d   = mem_readdata[7:0];
      tlb_va_d = vaddr_q;
      tlbw_d   = 1'b1;
    end
    busy_d = (state_d != S_IDLE);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      vaddr_q    <= '0;
      mem_read_q <= 1'b0;
      mem_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pf_q       <= 1'b0;
      af_q       <= 1'b0;
      ppn_q      <= '0;
      bits_q     <= '0;
      tlb_va_q   <= '0;
      tlbw_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      vaddr_q    <= vaddr_d;
      mem_read_q <= mem_read_d;
      mem_addr_q <= mem_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pf_q       <= pf_d;
      af_q       <= af_d;
      ppn_q      <= ppn_d;
      bits_q     <= bits_d;
      tlb_va_q   <= tlb_va_d;
      tlbw_q     <= tlbw_d;
    end
  end

  assign resolve_busy             = busy_q;
  assign resolve_done             = done_q;
  assign resolve_pagefault        = pf_q;
  assign resolve_accessfault      = af_q;
  assign resolve_physical_address = ppn_q;
  assign resolve_access_bits      = bits_q;
  assign mem_read                 = mem_read_q;
  assign mem_address              = mem_addr_q;
  assign tlb_write                = tlbw_q;
  assign tlb_virtual_address_w    = tlb_va_q;
  assign tlb_accesstag_w          = bits_q;
  assign tlb_phys_w               = ppn_q;

endmodule

// File: tb/tb_armleocpu_ptw_sv32.sv
// Bench for the Sv32 walker: page-table memory model, scoreboard of expected
// walk results, and scenario tasks run in sequence.
module tb_armleocpu_ptw_sv32;
  localparam bit SP = 1'b1;

  logic        clk, rst;
  logic [21:0] satp_ppn;
  logic        resolve_request;
  logic [19:0] resolve_virtual_address;
  logic        resolve_busy, resolve_done, resolve_pagefault, resolve_accessfault;
  logic [21:0] resolve_physical_address;
  logic [7:0]  resolve_access_bits;
  logic        mem_read;
  logic [33:0] mem_address;
  logic        mem_done, mem_error;
  logic [31:0] mem_readdata;
  logic        tlb_write;
  logic [19:0] tlb_virtual_address_w;
  logic [7:0]  tlb_accesstag_w;
  logic [21:0] tlb_phys_w;

  armleocpu_ptw_sv32 #(.ENABLE_SUPERPAGE(SP)) dut (
    .clk(clk), .rst(rst), .satp_ppn(satp_ppn), .resolve_request(resolve_request),
    .resolve_virtual_address(resolve_virtual_address), .resolve_busy(resolve_busy),
    .resolve_done(resolve_done), .resolve_pagefault(resolve_pagefault),
    .resolve_accessfault(resolve_accessfault), .resolve_physical_address(resolve_physical_address),
    .resolve_access_bits(resolve_access_bits), .mem_read(mem_read), .mem_address(mem_address),
    .mem_done(mem_done), .mem_error(mem_error), .mem_readdata(mem_readdata),
    .tlb_write(tlb_write), .tlb_virtual_address_w(tlb_virtual_address_w),
    .tlb_accesstag_w(tlb_accesstag_w), .tlb_phys_w(tlb_phys_w)
  );

  typedef struct {
    logic        pf;
    logic        af;
    logic [21:0] ppn;
    logic [7:0]  bits;
    logic [19:0] va;
    int          nreads;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [logic [33:0]];
  bit          err_at [logic [33:0]];

  int n_checks = 0, n_fail = 0;
  int cyc = 0, done_cnt = 0, reads_cnt = 0, reads_at_last = 0;
  int start_cyc = 0, last_done_cyc = 0, mem_delay = 0;
  bit inject_stale = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rd(input logic [33:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // Reference walk over the bench's page-table memory
  function automatic exp_t model(input logic [21:0] s, input logic [19:0] v);
    exp_t e;
    logic [33:0] a;
    logic [31:0] p;
    e.pf = 0; e.af = 0; e.ppn = '0; e.bits = '0; e.va = v; e.nreads = 1;
    a = {s, v[19:10], 2'b00};
    p = rd(a);
    if (err_at.exists(a)) e.af = 1;
    else if (!p[0] || (p[2] && !p[1])) e.pf = 1;
    else if (p[1] || p[3]) begin
      if (!SP || p[19:10] != 10'd0) e.pf = 1;
      else begin e.ppn = {p[31:20], v[9:0]}; e.bits = p[7:0]; end
    end else begin
      e.nreads = 2;
      a = {p[31:10], v[9:0], 2'b00};
      p = rd(a);
      if (err_at.exists(a)) e.af = 1;
      else if (!p[0] || (p[2] && !p[1])) e.pf = 1;
      else if (p[1] || p[3]) begin e.ppn = p[31:10]; e.bits = p[7:0]; end
      else e.pf = 1;
    end
    return e;
  endfunction

  // Memory responder: answers mem_read after mem_delay cycles; checks address stability
  initial begin
    int          wcnt;
    logic        prev_read;
    logic [33:0] prev_addr;
    wcnt = 0; prev_read = 0; prev_addr = '0;
    mem_done = 0; mem_error = 0; mem_readdata = '0;
    forever begin
      @(negedge clk);
      mem_done = 0;
      mem_error = 0;
      if (mem_read && prev_read) begin
        n_checks++;
        if (mem_address !== prev_addr) begin
          n_fail++;
          $display("FAIL addr_stable: mem_address %h, required %h", mem_address, prev_addr);
        end
      end
      prev_read = mem_read;
      prev_addr = mem_address;
      if (inject_stale) begin
        mem_done = 1; mem_readdata = 32'h2000000F; inject_stale = 0;
      end else if (mem_read && !rst) begin
        if (wcnt < mem_delay) wcnt++;
        else begin
          mem_done = 1;
          mem_readdata = rd(mem_address);
          mem_error = err_at.exists(mem_address);
          wcnt = 0;
          reads_cnt++;
        end
      end else wcnt = 0;
    end
  end

  // Scoreboard monitor: each done pops one expected walk result
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (resolve_done === 1'b1) begin
      done_cnt++;
      last_done_cyc = cyc;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: resolve_done=1, required no done (scoreboard empty)");
      end else begin
        e = sb.pop_front();
        n_checks += 4;
        if (resolve_pagefault !== e.pf) begin
          n_fail++; $display("FAIL pagefault va=%h: got %b, required %b", e.va, resolve_pagefault, e.pf);
        end
        if (resolve_accessfault !== e.af) begin
          n_fail++; $display("FAIL accessfault va=%h: got %b, required %b", e.va, resolve_accessfault, e.af);
        end
        if (tlb_write !== (!e.pf && !e.af)) begin
          n_fail++; $display("FAIL tlb_write va=%h: got %b, required %b", e.va, tlb_write, !e.pf && !e.af);
        end
        if ((reads_cnt - reads_at_last) != e.nreads) begin
          n_fail++; $display("FAIL mem_reads va=%h: got %0d, required %0d", e.va, reads_cnt - reads_at_last, e.nreads);
        end
        if (!e.pf && !e.af) begin
          n_checks += 3;
          if (resolve_physical_address !== e.ppn || tlb_phys_w !== e.ppn) begin
            n_fail++; $display("FAIL ppn va=%h: got %h/%h, required %h", e.va, resolve_physical_address, tlb_phys_w, e.ppn);
          end
          if (resolve_access_bits !== e.bits || tlb_accesstag_w !== e.bits) begin
            n_fail++; $display("FAIL bits va=%h: got %h/%h, required %h", e.va, resolve_access_bits, tlb_accesstag_w, e.bits);
          end
          if (tlb_virtual_address_w !== e.va) begin
            n_fail++; $display("FAIL tlb_va: got %h, required %h", tlb_virtual_address_w, e.va);
          end
        end
      end
      reads_at_last = reads_cnt;
    end
  end

  task automatic set_4k(input logic [21:0] s, input logic [19:0] v, input logic [21:0] l0ppn, input logic [31:0] pte);
    mem[{s, v[19:10], 2'b00}] = {l0ppn, 10'h001};
    mem[{l0ppn, v[9:0], 2'b00}] = pte;
  endtask

  task automatic issue(input logic [21:0] s, input logic [19:0] v, input bit hold);
    @(negedge clk);
    satp_ppn = s;
    resolve_virtual_address = v;
    resolve_request = 1'b1;
    sb.push_back(model(s, v));
    start_cyc = cyc;
    if (!hold) begin
      @(negedge clk);
      resolve_request = 1'b0;
    end
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while (resolve_done !== 1'b1 && k < 300);
    n_checks++;
    if (resolve_done !== 1'b1) begin
      n_fail++; $display("FAIL %s_timeout: no resolve_done within %0d cycles", name, k);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; resolve_request = 1'b0; satp_ppn = '0; resolve_virtual_address = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_checks += 3;
    if ({resolve_busy, resolve_done, resolve_pagefault, resolve_accessfault, mem_read, tlb_write} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b, required 000000",
        {resolve_busy, resolve_done, resolve_pagefault, resolve_accessfault, mem_read, tlb_write});
    end
    if (mem_address !== 34'h0 || resolve_physical_address !== 22'h0 || resolve_access_bits !== 8'h0) begin
      n_fail++; $display("FAIL reset_data: addr %h ppn %h bits %h, required 0", mem_address, resolve_physical_address, resolve_access_bits);
    end
    if (tlb_virtual_address_w !== 20'h0 || tlb_phys_w !== 22'h0 || tlb_accesstag_w !== 8'h0) begin
      n_fail++; $display("FAIL reset_tlb: va %h phys %h tag %h, required 0", tlb_virtual_address_w, tlb_phys_w, tlb_accesstag_w);
    end
  endtask

  task automatic test_4k();
    set_4k(22'h00100, 20'h12345, 22'h00200, 32'h1234500F);
    mem_delay = 0;
    issue(22'h00100, 20'h12345, 0);
    wait_done("4k");
    n_checks++;
    if (last_done_cyc - start_cyc - 1 != 3) begin
      n_fail++; $display("FAIL 4k_latency: got %0d edges, required 3", last_done_cyc - start_cyc - 1);
    end
    mem_delay = 3;
    issue(22'h00100, 20'h12345, 0);
    wait_done("4k_slow");
  endtask

  task automatic test_megapage();
    mem[{22'h00210, 10'h02A, 2'b00}] = 32'h2000000F;
    mem[{22'h00211, 10'h07C, 2'b00}] = 32'h2000040F;
    mem_delay = 0;
    issue(22'h00210, 20'h0ABCD, 0);
    wait_done("mega");
    n_checks++;
    if (last_done_cyc - start_cyc - 1 != 1) begin
      n_fail++; $display("FAIL mega_latency: got %0d edges, required 1", last_done_cyc - start_cyc - 1);
    end
    issue(22'h00211, 20'h1F000, 0);
    wait_done("mega_misaligned");
  endtask

  task automatic test_pagefault();
    mem_delay = 1;
    issue(22'h00300, 20'h00001, 0);
    wait_done("pf_invalid");
    set_4k(22'h00301, 20'h00402, 22'h01000, 32'h00000005);
    issue(22'h00301, 20'h00402, 0);
    wait_done("pf_wonly");
    set_4k(22'h00302, 20'h00803, 22'h01001, 32'h00000001);
    issue(22'h00302, 20'h00803, 0);
    wait_done("pf_nonleaf_l0");
  endtask

  task automatic test_accessfault();
    set_4k(22'h00303, 20'h12345, 22'h01002, 32'h0000100F);
    err_at[{22'h01002, 10'h345, 2'b00}] = 1;
    mem_delay = 0;
    issue(22'h00303, 20'h12345, 0);
    wait_done("af_l0");
    mem[{22'h00304, 10'h000, 2'b00}] = 32'h2000000F;
    err_at[{22'h00304, 10'h000, 2'b00}] = 1;
    issue(22'h00304, 20'h00000, 0);
    wait_done("af_l1");
  endtask

  task automatic test_busy_hold();
    int d0;
    d0 = done_cnt;
    mem_delay = 2;
    issue(22'h00210, 20'h0ABCD, 1);
    wait_done("hold");
    @(posedge clk);
    #1 resolve_request = 1'b0;
    repeat (10) @(negedge clk);
    n_checks += 2;
    if (done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL hold_single_done: got %0d dones, required 1", done_cnt - d0);
    end
    if (resolve_busy !== 1'b0 || mem_read !== 1'b0) begin
      n_fail++; $display("FAIL hold_idle: busy %b mem_read %b, required 0 0", resolve_busy, mem_read);
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < 4; i++) begin
      mem_delay = i;
      case (i)
        0: issue(22'h00100, 20'h12345, 0);
        1: issue(22'h00210, 20'h0ABCD, 0);
        2: issue(22'h00301, 20'h00402, 0);
        default: issue(22'h00303, 20'h12345, 0);
      endcase
      wait_done("b2b");
    end
    repeat (3) @(negedge clk);
    n_checks += 2;
    if (done_cnt - d0 != 4) begin
      n_fail++; $display("FAIL b2b_count: got %0d dones, required 4", done_cnt - d0);
    end
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL b2b_leftover: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_reset_mid();
    int d0, r0, k;
    mem_delay = 4;
    r0 = reads_cnt;
    issue(22'h00100, 20'h12345, 0);
    k = 0;
    while (!(mem_read === 1'b1 && reads_cnt == r0 + 1) && k < 100) begin
      @(negedge clk); k++;
    end
    n_checks++;
    if (k >= 100) begin
      n_fail++; $display("FAIL rstmid_l0_timeout: L0 read not seen within %0d cycles", k);
    end
    d0 = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    n_checks++;
    if (mem_read !== 1'b0 || resolve_busy !== 1'b0 || resolve_done !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_abort: mem_read %b busy %b done %b, required 0 0 0", mem_read, resolve_busy, resolve_done);
    end
    inject_stale = 1;
    repeat (8) @(negedge clk);
    n_checks += 2;
    if (done_cnt != d0) begin
      n_fail++; $display("FAIL rstmid_no_done: got %0d dones, required 0", done_cnt - d0);
    end
    if (resolve_busy !== 1'b0 || mem_read !== 1'b0) begin
      n_fail++; $display("FAIL stale_ignored: busy %b mem_read %b, required 0 0", resolve_busy, mem_read);
    end
    reads_at_last = reads_cnt;
    mem_delay = 0;
    issue(22'h00100, 20'h12345, 0);
    wait_done("recover");
  endtask

  initial begin
    test_reset();
    test_4k();
    test_megapage();
    test_pagefault();
    test_accessfault();
    test_busy_hold();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL final_scoreboard: got %0d pending, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
